// File: rtl/sw_led_pkg.sv
// Shared types for the switch-to-LED controller.
//   mode_e : LED output mode selected at run time
//   MODE_W : width of the mode select bus
package sw_led_pkg;

  localparam int unsigned MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_DIRECT = 2'b00,  // led follows debounced switch
    MODE_TOGGLE = 2'b01,  // led flips on each press
    MODE_BLINK  = 2'b10,  // debounced switch gated by blink phase
    MODE_COUNT  = 2'b11   // led shows channel-0 press count
  } mode_e;

endpackage : sw_led_pkg

// File: rtl/debounce_ch.sv
// Single-channel switch conditioner: 2-FF synchroniser, debounce counter,
// and rising-edge (press) detector.
// Ports:
//   clck  in  system clock, rising edge
//   rst_n in  asynchronous active-low reset
//   raw   in  raw switch level, asynchronous to clck
//   level out debounced level (registered)
//   rise  out one-cycle pulse in the first cycle level reads 1 (registered)
module debounce_ch #(
  parameter int unsigned DEB_CYCLES = 16
) (
  input  logic clck,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int unsigned CNT_W = (DEB_CYCLES < 2) ? 1 : $clog2(DEB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DEB_CYCLES - 1);

  logic             s1_q;
  logic             s2_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             level_q;
  logic             level_d;
  logic             rise_q;
  logic             rise_d;

  // Synchroniser chain into the clck domain.
  always_ff @(posedge clck or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= raw;
      s2_q <= s1_q;
    end
  end

  // Count consecutive disagreeing cycles; any agreement restarts the count.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    rise_d  = 1'b0;
    if (s2_q != level_q) begin
      if (cnt_q == CNT_TERM) begin
        level_d = s2_q;
        // level_q is the opposite of s2_q here, so s2_q=1 means 0->1.
        rise_d  = s2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Debounce state and press pulse.
  always_ff @(posedge clck or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;

endmodule : debounce_ch

// File: rtl/sw_led_ctrl.sv
// Switch-to-LED controller: N_CH raw switches are synchronised and debounced,
// then drive N_CH registered LEDs through a run-time selectable mode.
// Ports:
//   clck   in  system clock, rising edge
//   rst_n  in  asynchronous active-low reset
//   sw     in  [N_CH]   raw switch levels
//   mode   in  [MODE_W] output mode (mode_e encoding)
//   led    out [N_CH]   registered LED drive
//   db_out out [N_CH]   debounced switch levels
module sw_led_ctrl
  import sw_led_pkg::*;
#(
  parameter int unsigned N_CH       = 4,
  parameter int unsigned DEB_CYCLES = 16,
  parameter int unsigned BLINK_W    = 22
) (
  input  logic              clck,
  input  logic              rst_n,
  input  logic [N_CH-1:0]   sw,
  input  logic [MODE_W-1:0] mode,
  output logic [N_CH-1:0]   led,
  output logic [N_CH-1:0]   db_out
);

  logic [N_CH-1:0]    db;
  logic [N_CH-1:0]    press;
  logic [N_CH-1:0]    tog_q;
  logic [N_CH-1:0]    tog_d;
  logic [N_CH-1:0]    cnt_q;
  logic [N_CH-1:0]    cnt_d;
  logic [BLINK_W-1:0] div_q;
  logic [BLINK_W-1:0] div_d;
  logic [N_CH-1:0]    led_q;
  logic [N_CH-1:0]    led_d;
  logic               phase;

  // Per-channel conditioning.
  for (genvar gi = 0; gi < int'(N_CH); gi++) begin : g_ch
    debounce_ch #(
      .DEB_CYCLES (DEB_CYCLES)
    ) u_deb (
      .clck  (clck),
      .rst_n (rst_n),
      .raw   (sw[gi]),
      .level (db[gi]),
      .rise  (press[gi])
    );
  end

  assign phase = div_q[BLINK_W-1];

  // Toggle regs, channel-0 press counter and free-running blink divider.
  always_comb begin
    tog_d = tog_q ^ press;
    cnt_d = cnt_q + N_CH'(press[0]);
    div_d = div_q + BLINK_W'(1);
  end

  // Output mode mux; mode is sampled directly so a change shows next edge.
  always_comb begin
    led_d = db;
    case (mode_e'(mode))
      MODE_DIRECT: led_d = db;
      MODE_TOGGLE: led_d = tog_q;
      MODE_BLINK:  led_d = db & {N_CH{phase}};
      MODE_COUNT:  led_d = cnt_q;
      default:     led_d = db;
    endcase
  end

  always_ff @(posedge clck or negedge rst_n) begin
    if (!rst_n) begin
      tog_q <= '0;
      cnt_q <= '0;
      div_q <= '0;
      led_q <= '0;
    end else begin
      tog_q <= tog_d;
      cnt_q <= cnt_d;
      div_q <= div_d;
      led_q <= led_d;
    end
  end

  assign led    = led_q;
  assign db_out = db;

endmodule : sw_led_ctrl

// File: tb/tb_sw_led_ctrl.sv
// Self-checking bench for sw_led_ctrl: directed scenarios with literal
// expectations plus a randomized run checked every cycle against a
// history-based behavioural model.
module tb_sw_led_ctrl;

  localparam int unsigned N   = 4;
  localparam int unsigned DEB = 4;
  localparam int unsigned BW  = 4;

  logic         clck;
  logic         rst_n;
  logic [N-1:0] sw;
  logic [1:0]   mode;
  logic [N-1:0] led;
  logic [N-1:0] db_out;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 0;

  sw_led_ctrl #(
    .N_CH       (N),
    .DEB_CYCLES (DEB),
    .BLINK_W    (BW)
  ) dut (
    .clck   (clck),
    .rst_n  (rst_n),
    .sw     (sw),
    .mode   (mode),
    .led    (led),
    .db_out (db_out)
  );

  initial clck = 1'b0;
  always #5 clck = ~clck;

  // ---------------- behavioural model ----------------
  logic [N-1:0]  samp[$];   // sw as seen at each edge, oldest first
  logic [N-1:0]  m_db, m_tog, m_cnt, m_press, m_led;
  logic [BW-1:0] m_div;

  task automatic model_reset();
    samp.delete();
    for (int k = 0; k < int'(DEB) + 2; k++) samp.push_back('0);
    m_db = '0; m_tog = '0; m_cnt = '0; m_press = '0; m_led = '0; m_div = '0;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clck or negedge rst_n);
      if (!rst_n) begin
        model_reset();
      end else begin
        logic [N-1:0] nled, ndb;
        bit all_diff;
        case (mode)
          2'b00:   nled = m_db;
          2'b01:   nled = m_tog;
          2'b10:   nled = m_db & {N{m_div[BW-1]}};
          default: nled = m_cnt;
        endcase
        samp.push_back(sw);
        // The synchronised view lags the pin by two edges; the level flips
        // once DEB consecutive synchronised samples all disagree with it.
        for (int i = 0; i < int'(N); i++) begin
          all_diff = 1;
          for (int k = 0; k < int'(DEB); k++)
            if (samp[samp.size() - 3 - k][i] == m_db[i]) all_diff = 0;
          ndb[i] = all_diff ? ~m_db[i] : m_db[i];
        end
        while (samp.size() > int'(DEB) + 3) void'(samp.pop_front());
        m_tog   = m_tog ^ m_press;
        m_cnt   = m_cnt + {3'b000, m_press[0]};
        m_div   = m_div + 1'b1;
        m_press = ndb & ~m_db;
        m_db    = ndb;
        m_led   = nled;
      end
    end
  end

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clck);
      if (chk_en) begin
        check("model_led", led, m_led);
        check("model_db", db_out, m_db);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clck);
    @(negedge clck);
  endtask

  task automatic reset_dut();
    @(negedge clck);
    rst_n = 1'b0;
    repeat (2) @(negedge clck);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [N-1:0] prev;
    int last_chg, n_chg;
    rst_n = 1'b0;
    sw    = '0;
    mode  = 2'b00;
    repeat (2) @(negedge clck);
    check("reset_led", led, 4'b0000);
    check("reset_db", db_out, 4'b0000);
    chk_en = 1;

    // 1: latency in DIRECT mode
    reset_dut();
    sw = 4'b0001; mode = 2'b00;
    tick();                                   // edge 0
    repeat (4) begin
      tick();
      check("t1_led_early", led, 4'b0000);
    end
    check("t1_db_edge4", db_out, 4'b0000);
    tick();                                   // edge 5
    check("t1_db_edge5", db_out, 4'b0001);
    check("t1_led_edge5", led, 4'b0000);
    tick();                                   // edge 6
    check("t1_led_edge6", led, 4'b0001);

    // 2: short glitch is rejected
    reset_dut();
    sw = 4'b0000;
    repeat (3) tick();
    sw = 4'b0010;
    repeat (3) tick();
    sw = 4'b0000;
    repeat (10) begin
      tick();
      check("t2_db", db_out, 4'b0000);
      check("t2_led", led, 4'b0000);
    end

    // 3: toggle mode on channel 2
    reset_dut();
    mode = 2'b01;
    for (int p = 0; p < 2; p++) begin
      sw = 4'b0100; repeat (8) tick();
      sw = 4'b0000; repeat (8) tick();
      check("t3_toggle", led, (p == 0) ? 4'b0100 : 4'b0000);
    end

    // 4: count mode wraps after 16 presses
    reset_dut();
    mode = 2'b11;
    for (int p = 0; p < 17; p++) begin
      sw = 4'b0001; repeat (8) tick();
      sw = 4'b0000; repeat (8) tick();
      check("t4_count", led, 4'((p + 1) % 16));
    end

    // 5: blink mode follows divider MSB (period 16, half-period 8)
    reset_dut();
    sw = 4'b1111; mode = 2'b10;
    repeat (10) tick();
    prev = led; last_chg = -1; n_chg = 0;
    for (int t = 0; t < 40; t++) begin
      tick();
      if (led != 4'b0000 && led != 4'b1111) check("t5_blink_val", led, 4'b1111);
      if (led != prev) begin
        if (last_chg >= 0) begin
          n_cmp++;
          if (t - last_chg != 8) begin
            n_bad++;
            $display("FAIL t5_blink_gap: got %0d expected 8", t - last_chg);
          end
        end
        last_chg = t; n_chg++;
      end
      prev = led;
    end
    n_cmp++;
    if (n_chg < 4) begin
      n_bad++;
      $display("FAIL t5_blink_changes: got %0d expected >=4", n_chg);
    end
    mode = 2'b00;
    tick();
    check("t5_mode_direct", led, 4'b1111);

    // 6: asynchronous reset mid-debounce
    reset_dut();
    sw = 4'b0001; mode = 2'b00;
    repeat (8) tick();
    check("t6_pre_led", led, 4'b0001);
    sw = 4'b0011;
    repeat (3) tick();
    @(posedge clck);
    #2 rst_n = 1'b0;
    #1;
    check("t6_async_led", led, 4'b0000);
    check("t6_async_db", db_out, 4'b0000);
    sw = 4'b0001;
    repeat (2) @(negedge clck);
    rst_n = 1'b1;
    tick();                                   // edge 0
    repeat (4) tick();
    check("t6_db_edge4", db_out, 4'b0000);
    tick();
    check("t6_db_edge5", db_out, 4'b0001);

    // Randomized run against the model
    reset_dut();
    for (int c = 0; c < 3000; c++) begin
      tick();
      if ($urandom_range(0, 4) == 0) sw[$urandom_range(0, N - 1)] ^= 1'b1;
      if ($urandom_range(0, 22) == 0) mode = 2'($urandom);
      if ($urandom_range(0, 499) == 0) begin
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
      end
    end

    repeat (2) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_sw_led_ctrl
